img_scale_copier: RTL and testbench

- Parametrised successor to the ROM→framebuffer copier.
- Reads a SRC_W×SRC_H grayscale source image from the synchronous image ROM and writes a scaled image into framebuffer RAM.
- Four modes: zoom-in by replication, decimation, 1:1 copy, and FxF box-average zoom-out.
- Publishes the destination dimensions so the display path can centre and address the image. Sits between the ROM, the ram2port write port and the VGA addressing logic.

---
 rtl/img_scale_pkg.sv | 36 +++
 rtl/scale_addr_gen.sv | 172 +++++++++++++++++
 rtl/img_scale_copier.sv | 145 ++++++++++++++
 tb/tb_img_scale_copier.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/img_scale_pkg.sv
// Shared definitions for the scaling ROM-to-framebuffer copier: mode encodings,
// FSM states and width helpers.
package img_scale_pkg;

    localparam logic [1:0] MODE_ZOOM = 2'b00;
    localparam logic [1:0] MODE_DEC  = 2'b01;
    localparam logic [1:0] MODE_COPY = 2'b10;
    localparam logic [1:0] MODE_AVG  = 2'b11;

    // Width of destination dimension and coordinate counters.
    localparam int unsigned DIM_W = 10;

    typedef enum logic [2:0] {
        StInit,
        StIssue,
        StCapture,
        StWrite,
        StDone
    } state_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((32'd1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    // FATOR^2 pixels of PIX_W bits each sum without overflow in this width.
    function automatic int unsigned acc_width(input int unsigned pix_w,
                                              input int unsigned fator);
        return pix_w + 2 * clog2(fator);
    endfunction

endpackage

// File: rtl/scale_addr_gen.sv
// Destination/source/sub-pixel counters and ROM/RAM address generation for the
// scaling copier.
module scale_addr_gen
    import img_scale_pkg::*;
#(
    parameter int unsigned SRC_W  = 160,
    parameter int unsigned SRC_H  = 120,
    parameter int unsigned FATOR  = 2,
    parameter int unsigned ADDR_W = 19
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              init_i,
    input  logic [1:0]        init_mode_i,
    input  logic [1:0]        mode_i,
    input  logic              read_step_i,
    input  logic              pixel_step_i,
    output logic              last_read_o,
    output logic              last_pixel_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    output logic [ADDR_W-1:0] ram_wraddr_o,
    output logic [DIM_W-1:0]  dst_w_o,
    output logic [DIM_W-1:0]  dst_h_o
);

    localparam int unsigned SubW = clog2(FATOR);

    localparam logic [SubW-1:0]   SubMax = SubW'(FATOR - 1);
    localparam logic [DIM_W-1:0]  FStep  = DIM_W'(FATOR);
    localparam logic [DIM_W-1:0]  ZoomW  = DIM_W'(SRC_W * FATOR);
    localparam logic [DIM_W-1:0]  ZoomH  = DIM_W'(SRC_H * FATOR);
    localparam logic [DIM_W-1:0]  DecW   = DIM_W'(SRC_W / FATOR);
    localparam logic [DIM_W-1:0]  DecH   = DIM_W'(SRC_H / FATOR);
    localparam logic [DIM_W-1:0]  CopyW  = DIM_W'(SRC_W);
    localparam logic [DIM_W-1:0]  CopyH  = DIM_W'(SRC_H);
    localparam logic [ADDR_W-1:0] SrcWA  = ADDR_W'(SRC_W);

    logic [DIM_W-1:0]  dst_x_q, dst_x_d, dst_y_q, dst_y_d;
    logic [DIM_W-1:0]  base_x_q, base_x_d, base_y_q, base_y_d;
    logic [SubW-1:0]   sub_x_q, sub_x_d, sub_y_q, sub_y_d;
    logic [SubW-1:0]   bx_q, bx_d, by_q, by_d;
    logic [ADDR_W-1:0] wraddr_q, wraddr_d;
    logic [DIM_W-1:0]  dst_w_q, dst_w_d, dst_h_q, dst_h_d;
    logic [DIM_W-1:0]  step;
    logic [DIM_W-1:0]  src_x, src_y;

    // Inner block offsets stay zero outside average mode.
    assign src_x        = base_x_q + DIM_W'(bx_q);
    assign src_y        = base_y_q + DIM_W'(by_q);
    assign rom_addr_o   = ADDR_W'(src_y) * SrcWA + ADDR_W'(src_x);
    assign ram_wraddr_o = wraddr_q;
    assign dst_w_o      = dst_w_q;
    assign dst_h_o      = dst_h_q;
    assign last_read_o  = (mode_i != MODE_AVG) || ((bx_q == SubMax) && (by_q == SubMax));
    assign last_pixel_o = (dst_x_q == dst_w_q - DIM_W'(1)) && (dst_y_q == dst_h_q - DIM_W'(1));
    assign step         = (mode_i == MODE_COPY) ? DIM_W'(1) : FStep;

    always_comb begin
        dst_x_d  = dst_x_q;
        dst_y_d  = dst_y_q;
        base_x_d = base_x_q;
        base_y_d = base_y_q;
        sub_x_d  = sub_x_q;
        sub_y_d  = sub_y_q;
        bx_d     = bx_q;
        by_d     = by_q;
        wraddr_d = wraddr_q;
        dst_w_d  = dst_w_q;
        dst_h_d  = dst_h_q;
        if (init_i) begin
            dst_x_d  = '0;
            dst_y_d  = '0;
            base_x_d = '0;
            base_y_d = '0;
            sub_x_d  = '0;
            sub_y_d  = '0;
            bx_d     = '0;
            by_d     = '0;
            wraddr_d = '0;
            unique case (init_mode_i)
                MODE_ZOOM: begin
                    dst_w_d = ZoomW;
                    dst_h_d = ZoomH;
                end
                MODE_COPY: begin
                    dst_w_d = CopyW;
                    dst_h_d = CopyH;
                end
                MODE_DEC, MODE_AVG: begin
                    dst_w_d = DecW;
                    dst_h_d = DecH;
                end
                default: begin
                    dst_w_d = CopyW;
                    dst_h_d = CopyH;
                end
            endcase
        end else begin
            if (read_step_i && !last_read_o) begin
                if (bx_q == SubMax) begin
                    bx_d = '0;
                    by_d = by_q + SubW'(1);
                end else begin
                    bx_d = bx_q + SubW'(1);
                end
            end
            // The final pixel leaves every counter frozen so rom_addr holds.
            if (pixel_step_i && !last_pixel_o) begin
                wraddr_d = wraddr_q + ADDR_W'(1);
                bx_d     = '0;
                by_d     = '0;
                if (dst_x_q == dst_w_q - DIM_W'(1)) begin
                    dst_x_d  = '0;
                    base_x_d = '0;
                    sub_x_d  = '0;
                    dst_y_d  = dst_y_q + DIM_W'(1);
                    if (mode_i == MODE_ZOOM) begin
                        if (sub_y_q == SubMax) begin
                            sub_y_d  = '0;
                            base_y_d = base_y_q + DIM_W'(1);
                        end else begin
                            sub_y_d = sub_y_q + SubW'(1);
                        end
                    end else begin
                        base_y_d = base_y_q + step;
                    end
                end else begin
                    dst_x_d = dst_x_q + DIM_W'(1);
                    if (mode_i == MODE_ZOOM) begin
                        if (sub_x_q == SubMax) begin
                            sub_x_d  = '0;
                            base_x_d = base_x_q + DIM_W'(1);
                        end else begin
                            sub_x_d = sub_x_q + SubW'(1);
                        end
                    end else begin
                        base_x_d = base_x_q + step;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dst_x_q  <= '0;
            dst_y_q  <= '0;
            base_x_q <= '0;
            base_y_q <= '0;
            sub_x_q  <= '0;
            sub_y_q  <= '0;
            bx_q     <= '0;
            by_q     <= '0;
            wraddr_q <= '0;
            dst_w_q  <= '0;
            dst_h_q  <= '0;
        end else begin
            dst_x_q  <= dst_x_d;
            dst_y_q  <= dst_y_d;
            base_x_q <= base_x_d;
            base_y_q <= base_y_d;
            sub_x_q  <= sub_x_d;
            sub_y_q  <= sub_y_d;
            bx_q     <= bx_d;
            by_q     <= by_d;
            wraddr_q <= wraddr_d;
            dst_w_q  <= dst_w_d;
            dst_h_q  <= dst_h_d;
        end
    end

endmodule

// File: rtl/img_scale_copier.sv
// Copies a grayscale image from the synchronous ROM into framebuffer RAM, scaled by
// replication, decimation, 1:1 copy or box averaging.
module img_scale_copier
    import img_scale_pkg::*;
#(
    parameter int unsigned SRC_W  = 160,
    parameter int unsigned SRC_H  = 120,
    parameter int unsigned FATOR  = 2,
    parameter int unsigned PIX_W  = 8,
    parameter int unsigned ADDR_W = 19
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        mode,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [PIX_W-1:0]  rom_data,
    output logic [ADDR_W-1:0] ram_wraddr,
    output logic [PIX_W-1:0]  ram_data,
    output logic              ram_wren,
    output logic              busy,
    output logic              done,
    output logic [9:0]        dst_w,
    output logic [9:0]        dst_h
);

    localparam int unsigned AccW  = acc_width(PIX_W, FATOR);
    localparam int unsigned Shift = 2 * clog2(FATOR);

    if ((FATOR < 2) || (FATOR > 8) || ((FATOR & (FATOR - 1)) != 0)) begin : g_bad_fator
        $error("FATOR must be a power of two between 2 and 8");
    end
    if (((SRC_W % FATOR) != 0) || ((SRC_H % FATOR) != 0)) begin : g_bad_src
        $error("SRC_W and SRC_H must be multiples of FATOR");
    end
    if ((SRC_W * FATOR > 1023) || (SRC_H * FATOR > 1023)) begin : g_bad_dim
        $error("zoomed destination does not fit the 10-bit dimension outputs");
    end

    state_e            state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [AccW-1:0]   acc_q, acc_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              init, read_step, pixel_step;
    logic              last_read, last_pixel;
    logic              restart;

    assign restart  = start || (mode != mode_q);
    assign busy     = busy_q;
    assign done     = done_q;
    assign ram_data = (mode_q == MODE_AVG) ? PIX_W'(acc_q >> Shift) : acc_q[PIX_W-1:0];

    scale_addr_gen #(
        .SRC_W  (SRC_W),
        .SRC_H  (SRC_H),
        .FATOR  (FATOR),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk_i        (clk),
        .rst_ni       (reset_n),
        .init_i       (init),
        .init_mode_i  (mode),
        .mode_i       (mode_q),
        .read_step_i  (read_step),
        .pixel_step_i (pixel_step),
        .last_read_o  (last_read),
        .last_pixel_o (last_pixel),
        .rom_addr_o   (rom_addr),
        .ram_wraddr_o (ram_wraddr),
        .dst_w_o      (dst_w),
        .dst_h_o      (dst_h)
    );

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        acc_d      = acc_q;
        busy_d     = busy_q;
        done_d     = done_q;
        init       = 1'b0;
        read_step  = 1'b0;
        pixel_step = 1'b0;
        ram_wren   = 1'b0;
        unique case (state_q)
            StInit: begin
                init    = 1'b1;
                mode_d  = mode;
                acc_d   = '0;
                busy_d  = 1'b1;
                done_d  = 1'b0;
                state_d = StIssue;
            end
            StIssue: begin
                state_d = StCapture;
            end
            StCapture: begin
                acc_d     = acc_q + AccW'(rom_data);
                read_step = 1'b1;
                state_d   = last_read ? StWrite : StIssue;
            end
            StWrite: begin
                ram_wren   = 1'b1;
                pixel_step = 1'b1;
                acc_d      = '0;
                if (last_pixel) begin
                    state_d = StDone;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d = StIssue;
                end
            end
            StDone: begin
                state_d = StDone;
            end
            default: begin
                state_d = StInit;
            end
        endcase
        // A write in flight this cycle still happens; only the next state changes.
        if ((state_q != StInit) && restart) begin
            state_d = StInit;
            busy_d  = 1'b1;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StInit;
            mode_q  <= MODE_ZOOM;
            acc_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            acc_q   <= acc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_img_scale_copier.sv
// Directed bench for img_scale_copier on a 4x4 source with ROM[a] = a and FATOR = 2.
module tb_img_scale_copier;

    localparam int unsigned SRC_W  = 4;
    localparam int unsigned SRC_H  = 4;
    localparam int unsigned FATOR  = 2;
    localparam int unsigned PIX_W  = 8;
    localparam int unsigned ADDR_W = 19;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [1:0]        mode = 2'b10;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] rom_addr;
    logic [PIX_W-1:0]  rom_data;
    logic [ADDR_W-1:0] ram_wraddr;
    logic [PIX_W-1:0]  ram_data;
    logic              ram_wren;
    logic              busy;
    logic              done;
    logic [9:0]        dst_w;
    logic [9:0]        dst_h;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int wr_cnt = 0;
    int t_init = 0;

    logic [ADDR_W-1:0] wr_addr_log [0:1023];
    logic [7:0]        wr_data_log [0:1023];
    int                wr_cyc_log  [0:1023];
    logic [7:0]        ram_mem     [0:255];

    byte unsigned dec_exp [4] = '{8'd0, 8'd2, 8'd8, 8'd10};
    byte unsigned avg_exp [4] = '{8'd2, 8'd4, 8'd10, 8'd12};

    img_scale_copier #(
        .SRC_W  (SRC_W),
        .SRC_H  (SRC_H),
        .FATOR  (FATOR),
        .PIX_W  (PIX_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .mode       (mode),
        .start      (start),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .ram_wraddr (ram_wraddr),
        .ram_data   (ram_data),
        .ram_wren   (ram_wren),
        .busy       (busy),
        .done       (done),
        .dst_w      (dst_w),
        .dst_h      (dst_h)
    );

    always #5 clk = ~clk;

    // Synchronous ROM holding its own address, plus a logging framebuffer.
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rom_data <= rom_addr[7:0];
        if (ram_wren) begin
            wr_addr_log[wr_cnt]       <= ram_wraddr;
            wr_data_log[wr_cnt]       <= ram_data;
            wr_cyc_log[wr_cnt]        <= cyc;
            ram_mem[ram_wraddr[7:0]]  <= ram_data;
            wr_cnt                    <= wr_cnt + 1;
        end
    end

    task automatic restart_mode(input logic [1:0] m, input logic pulse);
        @(negedge clk);
        mode  = m;
        start = pulse;
        @(posedge clk);
        #1;
        start  = 1'b0;
        t_init = cyc;
    endtask

    task automatic wait_done(input int budget, output int lat);
        lat = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = cyc - t_init;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int lat;
        int base;
        reset_n = 1'b0;
        mode    = 2'b10;
        start   = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (ram_wren !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl wren=%b busy=%b done=%b required 0 0 0", ram_wren, busy, done);
        end
        checks++;
        if (dst_w !== 10'd0 || dst_h !== 10'd0 || rom_addr !== '0 || ram_wraddr !== '0) begin
            errors++;
            $display("FAIL reset_data dst=%0dx%0d rom=%0d wr=%0d required all 0",
                     dst_w, dst_h, rom_addr, ram_wraddr);
        end
        base    = wr_cnt;
        reset_n = 1'b1;
        t_init  = cyc;
        repeat (5) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL copy_busy busy=%b required 1", busy);
        end
        wait_done(200, lat);
        checks++;
        if (lat != 49) begin
            errors++;
            $display("FAIL copy_latency got=%0d required 49", lat);
        end
        checks++;
        if (wr_cnt - base != 16 || dst_w !== 10'd4 || dst_h !== 10'd4 || busy !== 1'b0) begin
            errors++;
            $display("FAIL copy_summary writes=%0d dst=%0dx%0d busy=%b required 16 4x4 0",
                     wr_cnt - base, dst_w, dst_h, busy);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (wr_addr_log[base + i] !== ADDR_W'(i) || wr_data_log[base + i] !== 8'(i)) begin
                errors++;
                $display("FAIL copy_write[%0d] addr=%0d data=%0d required %0d %0d",
                         i, wr_addr_log[base + i], wr_data_log[base + i], i, i);
            end
        end
        repeat (3) @(negedge clk);
        checks++;
        if (done !== 1'b1 || rom_addr !== ADDR_W'(15) || ram_wren !== 1'b0) begin
            errors++;
            $display("FAIL copy_hold done=%b rom=%0d wren=%b required 1 15 0", done, rom_addr, ram_wren);
        end
    endtask

    task automatic test_zoom();
        int lat;
        int base;
        base = wr_cnt;
        restart_mode(2'b00, 1'b0);
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL zoom_init done=%b busy=%b required 0 1", done, busy);
        end
        wait_done(1000, lat);
        checks++;
        if (lat != 193) begin
            errors++;
            $display("FAIL zoom_latency got=%0d required 193", lat);
        end
        checks++;
        if (wr_cnt - base != 64 || dst_w !== 10'd8 || dst_h !== 10'd8) begin
            errors++;
            $display("FAIL zoom_summary writes=%0d dst=%0dx%0d required 64 8x8",
                     wr_cnt - base, dst_w, dst_h);
        end
        checks++;
        if (ram_mem[9] !== 8'd0 || ram_mem[10] !== 8'd1 || ram_mem[18] !== 8'd5
            || ram_mem[63] !== 8'd15) begin
            errors++;
            $display("FAIL zoom_pixels r9=%0d r10=%0d r18=%0d r63=%0d required 0 1 5 15",
                     ram_mem[9], ram_mem[10], ram_mem[18], ram_mem[63]);
        end
        checks++;
        if (wr_addr_log[base + 63] !== ADDR_W'(63) || wr_addr_log[base + 8] !== ADDR_W'(8)) begin
            errors++;
            $display("FAIL zoom_addr a8=%0d a63=%0d required 8 63",
                     wr_addr_log[base + 8], wr_addr_log[base + 63]);
        end
    endtask

    task automatic test_decimate();
        int lat;
        int base;
        base = wr_cnt;
        restart_mode(2'b01, 1'b0);
        wait_done(200, lat);
        checks++;
        if (lat != 13 || wr_cnt - base != 4 || dst_w !== 10'd2 || dst_h !== 10'd2) begin
            errors++;
            $display("FAIL dec_summary lat=%0d writes=%0d dst=%0dx%0d required 13 4 2x2",
                     lat, wr_cnt - base, dst_w, dst_h);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (wr_addr_log[base + i] !== ADDR_W'(i) || wr_data_log[base + i] !== dec_exp[i]) begin
                errors++;
                $display("FAIL dec_write[%0d] addr=%0d data=%0d required %0d %0d",
                         i, wr_addr_log[base + i], wr_data_log[base + i], i, dec_exp[i]);
            end
        end
    endtask

    task automatic test_average();
        int lat;
        int base;
        base = wr_cnt;
        restart_mode(2'b11, 1'b0);
        wait_done(400, lat);
        checks++;
        if (lat != 37 || wr_cnt - base != 4 || dst_w !== 10'd2 || dst_h !== 10'd2) begin
            errors++;
            $display("FAIL avg_summary lat=%0d writes=%0d dst=%0dx%0d required 37 4 2x2",
                     lat, wr_cnt - base, dst_w, dst_h);
        end
        checks++;
        if (wr_cyc_log[base + 1] - wr_cyc_log[base] != 9) begin
            errors++;
            $display("FAIL avg_period got=%0d required 9", wr_cyc_log[base + 1] - wr_cyc_log[base]);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (wr_addr_log[base + i] !== ADDR_W'(i) || wr_data_log[base + i] !== avg_exp[i]) begin
                errors++;
                $display("FAIL avg_write[%0d] addr=%0d data=%0d required %0d %0d",
                         i, wr_addr_log[base + i], wr_data_log[base + i], i, avg_exp[i]);
            end
        end
    endtask

    // Restart from DONE with start, then a second start landing in INIT.
    task automatic test_back_to_back();
        int lat;
        int base;
        base = wr_cnt;
        restart_mode(2'b11, 1'b1);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(400, lat);
        checks++;
        if (lat != 37 || wr_cnt - base != 4) begin
            errors++;
            $display("FAIL b2b_summary lat=%0d writes=%0d required 37 4", lat, wr_cnt - base);
        end
        checks++;
        if (wr_data_log[base + 3] !== 8'd12) begin
            errors++;
            $display("FAIL b2b_last data=%0d required 12", wr_data_log[base + 3]);
        end
    endtask

    task automatic test_start_and_mode();
        int lat;
        int base;
        base = wr_cnt;
        restart_mode(2'b01, 1'b1);
        wait_done(200, lat);
        checks++;
        if (lat != 13 || wr_cnt - base != 4 || wr_data_log[base + 2] !== 8'd8) begin
            errors++;
            $display("FAIL start_mode lat=%0d writes=%0d d2=%0d required 13 4 8",
                     lat, wr_cnt - base, wr_data_log[base + 2]);
        end
    endtask

    task automatic test_mode_switch();
        int  lat;
        int  base;
        bit  found;
        base  = wr_cnt;
        found = 1'b0;
        restart_mode(2'b00, 1'b0);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (wr_cnt - base == 4) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL switch_reach writes=%0d required 4", wr_cnt - base);
        end
        mode = 2'b01;
        @(posedge clk);
        #1;
        t_init = cyc;
        base   = wr_cnt;
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL switch_init done=%b busy=%b required 0 1", done, busy);
        end
        wait_done(200, lat);
        checks++;
        if (lat != 13 || wr_cnt - base != 4) begin
            errors++;
            $display("FAIL switch_summary lat=%0d writes=%0d required 13 4", lat, wr_cnt - base);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (wr_addr_log[base + i] !== ADDR_W'(i) || wr_data_log[base + i] !== dec_exp[i]) begin
                errors++;
                $display("FAIL switch_write[%0d] addr=%0d data=%0d required %0d %0d",
                         i, wr_addr_log[base + i], wr_data_log[base + i], i, dec_exp[i]);
            end
        end
    endtask

    task automatic test_reset_midwrite();
        int  lat;
        int  base;
        bit  found;
        base  = wr_cnt;
        found = 1'b0;
        restart_mode(2'b10, 1'b0);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ram_wren === 1'b1 && wr_cnt - base >= 2) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL midwrite_reach wren=%b required 1", ram_wren);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (ram_wren !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL midwrite_async wren=%b busy=%b done=%b required 0 0 0", ram_wren, busy, done);
        end
        repeat (2) @(negedge clk);
        base    = wr_cnt;
        reset_n = 1'b1;
        t_init  = cyc;
        wait_done(200, lat);
        checks++;
        if (lat != 49 || wr_cnt - base != 16) begin
            errors++;
            $display("FAIL midwrite_summary lat=%0d writes=%0d required 49 16", lat, wr_cnt - base);
        end
        for (int i = 0; i < 16; i += 5) begin
            checks++;
            if (wr_addr_log[base + i] !== ADDR_W'(i) || wr_data_log[base + i] !== 8'(i)) begin
                errors++;
                $display("FAIL midwrite_write[%0d] addr=%0d data=%0d required %0d %0d",
                         i, wr_addr_log[base + i], wr_data_log[base + i], i, i);
            end
        end
    endtask

    initial begin
        test_reset();
        test_zoom();
        test_decimate();
        test_average();
        test_back_to_back();
        test_start_and_mode();
        test_mode_switch();
        test_reset_midwrite();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
